fb_draw_engine: RTL

// - Command-driven pixel writer feeding the 214x160x3-bit framebuffer that the VGA scan-out stage reads.
// - Accepts plot, rectangle-fill and clear commands; emits one framebuffer write per cycle through a stallable write port.
// - Sits between the CPU command path and the framebuffer write port, upstream of the VGA scan-out stage.

---
 rtl/fb_draw_engine.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fb_draw_engine.sv
// Command-driven rectangle writer for the 214x160x3-bit framebuffer.
// PLOT, FILL and CLEAR become one clamped rectangle, emitted one pixel per accepted write.
module fb_draw_engine #(
   parameter int FB_WIDTH  = 214,
   parameter int FB_HEIGHT = 160,
   parameter int ADDR_W    = 16
) (
   input  logic              clk,
   input  logic              rst_sync,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [7:0]        cmd_x0,
   input  logic [7:0]        cmd_y0,
   input  logic [7:0]        cmd_x1,
   input  logic [7:0]        cmd_y1,
   input  logic [2:0]        cmd_color,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_waddr,
   output logic [2:0]        fb_wdata,
   input  logic              fb_wready,
   output logic              busy,
   output logic              done
);

   localparam logic [7:0]        X_MAX      = 8'(FB_WIDTH - 1);
   localparam logic [7:0]        Y_MAX      = 8'(FB_HEIGHT - 1);
   localparam logic [7:0]        X_LIM      = 8'(FB_WIDTH);
   localparam logic [7:0]        Y_LIM      = 8'(FB_HEIGHT);
   localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(FB_WIDTH);

   localparam logic [1:0] OP_PLOT  = 2'd0;
   localparam logic [1:0] OP_FILL  = 2'd1;
   localparam logic [1:0] OP_CLEAR = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRAW  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [7:0]        x0_r, y0_r, x1_r, y1_r;
   logic [7:0]        x_r, y_r;
   logic [2:0]        color_r;
   logic              nop_r;
   logic [ADDR_W-1:0] row_base_r;
   logic              empty;
   logic              advance;
   logic              last_pix;

   function automatic logic [7:0] sat_coord(input logic [7:0] v, input logic [7:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   assign empty = nop_r | (x0_r > x1_r) | (y0_r > y1_r) |
                  (x0_r >= X_LIM) | (y0_r >= Y_LIM);
   assign advance  = (state == DRAW) & fb_wready;
   assign last_pix = (x_r == x1_r) & (y_r == y1_r);

   // Control: only the state register needs reset; outputs are decoded from it.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      fb_we     = 1'b0;
      fb_waddr  = '0;
      fb_wdata  = '0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) state_nxt = SETUP;
         end
         SETUP: begin
            state_nxt = empty ? DONE : DRAW;
         end
         DRAW: begin
            fb_we    = 1'b1;
            fb_waddr = row_base_r + {{(ADDR_W-8){1'b0}}, x_r};
            fb_wdata = color_r;
            if (fb_wready && last_pix) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: command latch at accept, row base via one multiply in SETUP,
   // then pure increments while drawing so a row wrap costs no extra cycle.
   always_ff @(posedge clk) begin
      if (state == IDLE && cmd_valid) begin
         color_r <= cmd_color;
         nop_r   <= (cmd_op == 2'd3);
         case (cmd_op)
            OP_PLOT: begin
               x0_r <= cmd_x0;
               y0_r <= cmd_y0;
               x1_r <= cmd_x0;
               y1_r <= cmd_y0;
            end
            OP_FILL: begin
               x0_r <= cmd_x0;
               y0_r <= cmd_y0;
               x1_r <= sat_coord(cmd_x1, X_MAX);
               y1_r <= sat_coord(cmd_y1, Y_MAX);
            end
            OP_CLEAR: begin
               x0_r <= 8'd0;
               y0_r <= 8'd0;
               x1_r <= X_MAX;
               y1_r <= Y_MAX;
            end
            default: begin
               x0_r <= cmd_x0;
               y0_r <= cmd_y0;
               x1_r <= cmd_x1;
               y1_r <= cmd_y1;
            end
         endcase
      end

      if (state == SETUP) begin
         row_base_r <= {{(ADDR_W-8){1'b0}}, y0_r} * ROW_STRIDE;
         x_r        <= x0_r;
         y_r        <= y0_r;
      end else if (advance && !last_pix) begin
         if (x_r != x1_r) begin
            x_r <= x_r + 8'd1;
         end else begin
            x_r        <= x0_r;
            y_r        <= y_r + 8'd1;
            row_base_r <= row_base_r + ROW_STRIDE;
         end
      end
   end

endmodule
